// File: rtl/window_pixel_streamer_if.sv
// Request, fraction-beat, memory and pixel-stream signals of window_pixel_streamer.
// The master modport is the streamer and the slave modport is its environment.
interface window_pixel_streamer_if #(
    parameter int pix_width  = 9,
    parameter int dec_width  = 15,
    parameter int int_width  = 10,
    parameter int addr_width = 20
);
    logic [4:0]            win_dim;
    logic                  req_val;
    logic                  req_rdy;
    logic [int_width-1:0]  req_x_int;
    logic [int_width-1:0]  req_y_int;
    logic [dec_width-1:0]  req_x_dec;
    logic [dec_width-1:0]  req_y_dec;
    logic [dec_width-1:0]  feature_x_dec;
    logic [dec_width-1:0]  feature_y_dec;
    logic                  feature_val;
    logic                  mem_req_val;
    logic                  mem_req_rdy;
    logic [addr_width-1:0] mem_req_addr;
    logic                  mem_resp_val;
    logic [pix_width-1:0]  mem_resp_data;
    logic [pix_width-1:0]  pix;
    logic                  pix_val;
    logic                  pix_rdy;
    logic [4:0]            row_counter;
    logic [4:0]            col_counter;
    logic                  done;

    modport master (
        input  win_dim, req_val, req_x_int, req_y_int, req_x_dec, req_y_dec,
               mem_req_rdy, mem_resp_val, mem_resp_data, pix_rdy,
        output req_rdy, feature_x_dec, feature_y_dec, feature_val, mem_req_val,
               mem_req_addr, pix, pix_val, row_counter, col_counter, done
    );

    modport slave (
        output win_dim, req_val, req_x_int, req_y_int, req_x_dec, req_y_dec,
               mem_req_rdy, mem_resp_val, mem_resp_data, pix_rdy,
        input  req_rdy, feature_x_dec, feature_y_dec, feature_val, mem_req_val,
               mem_req_addr, pix, pix_val, row_counter, col_counter, done
    );
endinterface

// File: rtl/window_pixel_streamer.sv
// Latches one feature request, emits its fraction beat, then fetches and streams the
// (win_dim+1)^2 pixel window row-major. Optional edge clamp: WINDOW_PIXEL_STREAMER_CLAMP_EN.
module window_pixel_streamer #(
    parameter int pix_width  = 9,
    parameter int dec_width  = 15,
    parameter int int_width  = 10,
    parameter int img_w      = 16,
    parameter int img_h      = 16,
    parameter int addr_width = 20,
    parameter int buf_depth  = 4
) (
    input  logic clk,
    input  logic reset,
    window_pixel_streamer_if.master bus
);
    localparam int CNT_W = $clog2(buf_depth + 1);
    localparam int PTR_W = (buf_depth > 1) ? $clog2(buf_depth) : 1;
    localparam int TOT_W = 12;
    localparam int POS_W = int_width + 2;

    typedef enum logic [1:0] {IDLE, FEAT, STREAM, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [int_width-1:0]  x_int_q, x_int_d, y_int_q, y_int_d;
    logic [dec_width-1:0]  x_dec_q, x_dec_d, y_dec_q, y_dec_d;
    logic [4:0]            win_dim_q, win_dim_d;
    logic [4:0]            row_q, row_d, col_q, col_d;
    logic [CNT_W-1:0]      in_flight_q, in_flight_d, count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TOT_W-1:0]      popped_q, popped_d;
    logic                  done_q, done_d;
    logic [pix_width-1:0]  buf_q [buf_depth];

    logic [CNT_W:0]        credit_s;
    logic                  active_s, mem_req_val_s, issue_s, push_s, pop_s;
    logic                  last_issue_s, last_pop_s;
    logic [5:0]            extent_s;
    logic [TOT_W-1:0]      total_s;
    logic [4:0]            half_s;
    logic [POS_W-1:0]      col_eff_s, row_eff_s;
    logic [addr_width-1:0] addr_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(buf_depth - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Credit = reads in flight + buffered pixels; issuing is allowed only below buf_depth.
    always_comb begin
        credit_s      = {1'b0, in_flight_q} + {1'b0, count_q};
        active_s      = (state_q == STREAM) || (state_q == DRAIN);
        mem_req_val_s = (state_q == STREAM) && (credit_s < (CNT_W + 1)'(buf_depth));
        issue_s       = mem_req_val_s && bus.mem_req_rdy;
        push_s        = active_s && bus.mem_resp_val;
        pop_s         = (count_q != {CNT_W{1'b0}}) && bus.pix_rdy;
        last_issue_s  = issue_s && (col_q == win_dim_q) && (row_q == win_dim_q);
        extent_s      = {1'b0, win_dim_q} + 6'd1;
        total_s       = TOT_W'(extent_s) * TOT_W'(extent_s);
        last_pop_s    = pop_s && (popped_q == (total_s - 12'd1));
    end

`ifdef WINDOW_PIXEL_STREAMER_CLAMP_EN
    localparam logic signed [POS_W-1:0] COL_MAX = POS_W'(img_w - 1);
    localparam logic signed [POS_W-1:0] ROW_MAX = POS_W'(img_h - 1);
    logic signed [POS_W-1:0] col_pos_s, row_pos_s;

    // Signed window position, clamped onto the image so edge pixels are replicated.
    always_comb begin
        half_s    = win_dim_q >> 1;
        col_pos_s = $signed({2'b00, x_int_q}) - $signed(POS_W'(half_s)) + $signed(POS_W'(col_q));
        row_pos_s = $signed({2'b00, y_int_q}) - $signed(POS_W'(half_s)) + $signed(POS_W'(row_q));
        if (col_pos_s[POS_W-1]) begin
            col_eff_s = {POS_W{1'b0}};
        end else if (col_pos_s > COL_MAX) begin
            col_eff_s = COL_MAX;
        end else begin
            col_eff_s = col_pos_s;
        end
        if (row_pos_s[POS_W-1]) begin
            row_eff_s = {POS_W{1'b0}};
        end else if (row_pos_s > ROW_MAX) begin
            row_eff_s = ROW_MAX;
        end else begin
            row_eff_s = row_pos_s;
        end
        addr_s = addr_width'(row_eff_s) * addr_width'(img_w) + addr_width'(col_eff_s);
    end
`else
    // Window position wraps modulo 2^int_width; the caller keeps the window inside the image.
    always_comb begin
        half_s    = win_dim_q >> 1;
        col_eff_s = {2'b00, x_int_q - int_width'(half_s) + int_width'(col_q)};
        row_eff_s = {2'b00, y_int_q - int_width'(half_s) + int_width'(row_q)};
        addr_s    = addr_width'(row_eff_s) * addr_width'(img_w) + addr_width'(col_eff_s);
    end
`endif

    // Next-state logic for the request FSM, issue counters and buffer bookkeeping.
    always_comb begin
        state_d   = state_q;
        x_int_d   = x_int_q;
        y_int_d   = y_int_q;
        x_dec_d   = x_dec_q;
        y_dec_d   = y_dec_q;
        win_dim_d = win_dim_q;
        row_d     = row_q;
        col_d     = col_q;
        done_d    = 1'b0;
        popped_d  = popped_q + TOT_W'(pop_s);
        case (state_q)
            IDLE: begin
                if (bus.req_val) begin
                    x_int_d   = bus.req_x_int;
                    y_int_d   = bus.req_y_int;
                    x_dec_d   = bus.req_x_dec;
                    y_dec_d   = bus.req_y_dec;
                    win_dim_d = bus.win_dim;
                    row_d     = 5'd0;
                    col_d     = 5'd0;
                    popped_d  = {TOT_W{1'b0}};
                    state_d   = FEAT;
                end else begin
                    state_d   = IDLE;
                end
            end
            FEAT: begin
                state_d = STREAM;
            end
            STREAM: begin
                if (issue_s) begin
                    if (col_q == win_dim_q) begin
                        col_d = 5'd0;
                        row_d = row_q + 5'd1;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                    state_d = last_issue_s ? DRAIN : STREAM;
                end else begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                if (last_pop_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case ({issue_s, push_s})
            2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
            2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
            default: in_flight_d = in_flight_q;
        endcase

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            x_int_q     <= {int_width{1'b0}};
            y_int_q     <= {int_width{1'b0}};
            x_dec_q     <= {dec_width{1'b0}};
            y_dec_q     <= {dec_width{1'b0}};
            win_dim_q   <= 5'd0;
            row_q       <= 5'd0;
            col_q       <= 5'd0;
            in_flight_q <= {CNT_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            popped_q    <= {TOT_W{1'b0}};
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_int_q     <= x_int_d;
            y_int_q     <= y_int_d;
            x_dec_q     <= x_dec_d;
            y_dec_q     <= y_dec_d;
            win_dim_q   <= win_dim_d;
            row_q       <= row_d;
            col_q       <= col_d;
            in_flight_q <= in_flight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            popped_q    <= popped_d;
            done_q      <= done_d;
        end
    end

    // Response buffer storage; pix always comes from here, never straight from memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < buf_depth; i++) begin
                buf_q[i] <= {pix_width{1'b0}};
            end
        end else if (push_s) begin
            buf_q[wr_ptr_q] <= bus.mem_resp_data;
        end
    end

    assign bus.req_rdy       = (state_q == IDLE);
    assign bus.feature_val   = (state_q == FEAT);
    assign bus.feature_x_dec = x_dec_q;
    assign bus.feature_y_dec = y_dec_q;
    assign bus.mem_req_val   = mem_req_val_s;
    assign bus.mem_req_addr  = addr_s;
    assign bus.pix_val       = (count_q != {CNT_W{1'b0}});
    assign bus.pix           = buf_q[rd_ptr_q];
    assign bus.row_counter   = row_q;
    assign bus.col_counter   = col_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_window_pixel_streamer.sv
// Self-checking bench for window_pixel_streamer: table vectors, randomized requests and
// hand-written corner sequences compared against a queue-based window model.
module tb_window_pixel_streamer;
    localparam int PIX_W  = 9;
    localparam int DEC_W  = 15;
    localparam int INT_W  = 10;
    localparam int IMG_W  = 16;
    localparam int IMG_H  = 16;
    localparam int ADDR_W = 20;
    localparam int BUF_D  = 4;

    typedef struct {
        int x, y, wd, xdec, ydec, mode, exp_first, exp_last, exp_n;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    window_pixel_streamer_if #(.pix_width(PIX_W), .dec_width(DEC_W), .int_width(INT_W),
                               .addr_width(ADDR_W)) bus ();

    window_pixel_streamer #(.pix_width(PIX_W), .dec_width(DEC_W), .int_width(INT_W),
                            .img_w(IMG_W), .img_h(IMG_H), .addr_width(ADDR_W),
                            .buf_depth(BUF_D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   pend_val = 1'b0;
    int   pend_addr = 0;
    int   exp_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int mem_word(input int a);
        return a & 32'h1FF;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Window model: every (row, col) of the window mapped to an image word address.
    function automatic void build_model(input int x, input int y, input int wd);
        int half, cx, ry;
        exp_q.delete();
        half = wd >> 1;
        for (int r = 0; r <= wd; r++) begin
            for (int c = 0; c <= wd; c++) begin
`ifdef WINDOW_PIXEL_STREAMER_CLAMP_EN
                cx = clampi(x - half + c, 0, IMG_W - 1);
                ry = clampi(y - half + r, 0, IMG_H - 1);
`else
                cx = (x - half + c) & ((1 << INT_W) - 1);
                ry = (y - half + r) & ((1 << INT_W) - 1);
`endif
                exp_q.push_back((ry * IMG_W + cx) & ((1 << ADDR_W) - 1));
            end
        end
    endfunction

    function automatic void add_vec(input int x, input int y, input int wd, input int xdec,
                                    input int ydec, input int mode, input int ef,
                                    input int el, input int en);
        vec_t v;
        v = '{x, y, wd, xdec, ydec, mode, ef, el, en};
        vecs.push_back(v);
    endfunction

    // mode: 0 all ready, 1 pix_rdy low 10 cycles after first pix_val,
    //       2 random mem_req_rdy, 3 random mem_req_rdy and pix_rdy.
    task automatic run_txn(input int x, input int y, input int wd, input int xdec,
                           input int ydec, input int mode, input int exp_first,
                           input int exp_last, input int exp_n, input int abort_pops);
        int t_acc = -1, fv_cnt = 0, fv_cyc = -1, fx = 0, fy = 0, first_req = -1;
        int first_resp = -1, last_resp = -1, first_pix = -1, last_pop = -1;
        int done_cnt = 0, done_cyc = -1, rdy_at_done = 0, issued = 0, pops = 0;
        int max_credit = 0, stab_err = 0, bp_start = -1, addr_err = 0, pix_err = 0;
        bit accepted = 1'b0, aborted = 1'b0, prev_stall = 1'b0;
        int prev_addr = 0;
        int got_addr[$];
        int got_pix[$];
        build_model(x, y, wd);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            bus.mem_resp_val  = pend_val;
            bus.mem_resp_data = pend_val ? PIX_W'(mem_word(pend_addr)) : {PIX_W{1'b0}};
            if (pend_val) begin
                if (first_resp < 0) first_resp = cyc;
                last_resp = cyc;
            end
            pend_val = 1'b0;
            bus.req_val = !accepted;
            if (!accepted) begin
                bus.win_dim   = 5'(wd);
                bus.req_x_int = INT_W'(x);
                bus.req_y_int = INT_W'(y);
                bus.req_x_dec = DEC_W'(xdec);
                bus.req_y_dec = DEC_W'(ydec);
            end else begin
                bus.win_dim   = 5'($urandom_range(0, 31));
                bus.req_x_int = INT_W'($urandom);
                bus.req_y_int = INT_W'($urandom);
            end
            bus.mem_req_rdy = (mode >= 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 1 && bp_start < 0 && bus.pix_val) bp_start = cyc;
            if (mode == 3) bus.pix_rdy = 1'($urandom_range(0, 1));
            else bus.pix_rdy = !(mode == 1 && bp_start >= 0 && cyc < bp_start + 10);
            #1;
            if (!accepted && bus.req_rdy) begin
                accepted = 1'b1;
                t_acc = cyc;
            end
            if (bus.feature_val) begin
                fv_cnt++;
                fv_cyc = cyc;
                fx = int'(bus.feature_x_dec);
                fy = int'(bus.feature_y_dec);
            end
            if (bus.mem_req_val && first_req < 0) first_req = cyc;
            if (prev_stall && (!bus.mem_req_val || int'(bus.mem_req_addr) != prev_addr)) stab_err++;
            prev_stall = bus.mem_req_val && !bus.mem_req_rdy;
            prev_addr  = int'(bus.mem_req_addr);
            if (bus.mem_req_val && bus.mem_req_rdy) begin
                got_addr.push_back(int'(bus.mem_req_addr));
                issued++;
                pend_val  = 1'b1;
                pend_addr = int'(bus.mem_req_addr);
            end
            if (bus.pix_val && first_pix < 0) first_pix = cyc;
            if (bus.pix_val && bus.pix_rdy) begin
                got_pix.push_back(int'(bus.pix));
                pops++;
                last_pop = cyc;
            end
            if (issued - pops > max_credit) max_credit = issued - pops;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                rdy_at_done = int'(bus.req_rdy);
            end
            @(posedge clk);
            cyc++;
            if (abort_pops > 0 && pops >= abort_pops) begin
                aborted = 1'b1;
                break;
            end
            if (done_cyc >= 0 && cyc > done_cyc + 2) break;
        end

        if (aborted) begin
            for (int i = 0; i < abort_pops; i++) begin
                if (got_pix[i] != mem_word(exp_q[i])) pix_err++;
            end
            check("pre_reset_pixels", pix_err, 0);
            @(negedge clk);
            reset = 1'b1;
            bus.req_val = 1'b0;
            bus.mem_resp_val = 1'b0;
            pend_val = 1'b0;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            reset = 1'b0;
            #1;
            check("rst_mid_req_rdy", int'(bus.req_rdy), 1);
            check("rst_mid_pix_val", int'(bus.pix_val), 0);
            check("rst_mid_row_counter", int'(bus.row_counter), 0);
            check("rst_mid_col_counter", int'(bus.col_counter), 0);
            check("rst_mid_mem_req_val", int'(bus.mem_req_val), 0);
            @(posedge clk);
            cyc++;
            return;
        end

        check("done_seen", int'(done_cyc >= 0), 1);
        check("feature_val_beats", fv_cnt, 1);
        check("feature_val_cycle", fv_cyc - t_acc, 1);
        check("feature_x_dec", fx, xdec);
        check("feature_y_dec", fy, ydec);
        check("first_req_latency", first_req - t_acc, 2);
        check("addr_count", got_addr.size(), exp_n);
        if (exp_first >= 0) begin
            check("first_addr", (got_addr.size() > 0) ? got_addr[0] : -1, exp_first);
            check("last_addr", (got_addr.size() > 0) ? got_addr[got_addr.size() - 1] : -1, exp_last);
        end
        addr_err = 0;
        pix_err  = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got_addr.size() || got_addr[i] != exp_q[i]) addr_err++;
            if (i >= got_pix.size() || got_pix[i] != mem_word(exp_q[i])) pix_err++;
        end
        check("addr_seq_errors", addr_err, 0);
        check("pix_count", got_pix.size(), exp_n);
        check("pix_seq_errors", pix_err, 0);
        check("done_pulses", done_cnt, 1);
        check("done_after_last_pop", done_cyc - last_pop, 1);
        check("req_rdy_at_done", rdy_at_done, 1);
        check("first_pix_latency", first_pix - first_resp, 1);
        check("credit_bound", int'(max_credit <= BUF_D), 1);
        check("addr_stable_in_stall", stab_err, 0);
        if (mode == 1 && exp_n > BUF_D) check("credit_saturates", max_credit, BUF_D);
        if (mode == 0) check("done_after_last_resp", done_cyc - last_resp, 2);
    endtask

    initial begin
        int wd, half, x, y;
        bus.req_val       = 1'b0;
        bus.win_dim       = 5'd0;
        bus.req_x_int     = {INT_W{1'b0}};
        bus.req_y_int     = {INT_W{1'b0}};
        bus.req_x_dec     = {DEC_W{1'b0}};
        bus.req_y_dec     = {DEC_W{1'b0}};
        bus.mem_req_rdy   = 1'b0;
        bus.mem_resp_val  = 1'b0;
        bus.mem_resp_data = {PIX_W{1'b0}};
        bus.pix_rdy       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_req_rdy", int'(bus.req_rdy), 1);
        check("reset_feature_val", int'(bus.feature_val), 0);
        check("reset_mem_req_val", int'(bus.mem_req_val), 0);
        check("reset_mem_req_addr", int'(bus.mem_req_addr), 0);
        check("reset_pix_val", int'(bus.pix_val), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_row_counter", int'(bus.row_counter), 0);
        check("reset_col_counter", int'(bus.col_counter), 0);

        // Responses arriving while idle must not reach the pixel buffer.
        @(negedge clk);
        bus.mem_resp_val  = 1'b1;
        bus.mem_resp_data = 9'h155;
        @(negedge clk);
        bus.mem_resp_val  = 1'b0;
        #1;
        check("idle_resp_ignored", int'(bus.pix_val), 0);
        check("idle_req_rdy", int'(bus.req_rdy), 1);

        add_vec(5, 5, 2, 32'h2000, 32'h1000, 0, 68, 102, 9);
        add_vec(5, 5, 2, 32'h2000, 32'h1000, 1, 68, 102, 9);
        add_vec(5, 5, 2, 32'h2000, 32'h1000, 2, 68, 102, 9);
        add_vec(3, 2, 0, 32'h1234, 32'h0567, 0, 35, 35, 1);
        add_vec(8, 8, 4, 32'h7FFF, 32'h0001, 3, 102, 170, 25);
        add_vec(1, 14, 1, 32'h0000, 32'h4000, 0, 225, 242, 4);
`ifdef WINDOW_PIXEL_STREAMER_CLAMP_EN
        add_vec(0, 0, 2, 32'h0100, 32'h0200, 0, 0, 17, 9);
        add_vec(15, 15, 2, 32'h0300, 32'h0400, 2, 238, 255, 9);
`endif
        foreach (vecs[i]) begin
            run_txn(vecs[i].x, vecs[i].y, vecs[i].wd, vecs[i].xdec, vecs[i].ydec,
                    vecs[i].mode, vecs[i].exp_first, vecs[i].exp_last, vecs[i].exp_n, 0);
        end

        // Reset after four pops, then a fresh request must complete normally.
        run_txn(5, 5, 2, 32'h2000, 32'h1000, 0, 68, 102, 9, 4);
        run_txn(6, 6, 2, 32'h0ABC, 32'h0DEF, 0, 85, 119, 9, 0);

        for (int n = 0; n < 12; n++) begin
            wd   = $urandom_range(0, 6);
            half = wd >> 1;
            x    = $urandom_range(half, IMG_W - 1 - (wd - half));
            y    = $urandom_range(half, IMG_H - 1 - (wd - half));
            run_txn(x, y, wd, $urandom_range(0, 32767), $urandom_range(0, 32767),
                    $urandom_range(0, 3), -1, -1, (wd + 1) * (wd + 1), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/window_pixel_streamer.md
Name: window_pixel_streamer

Overview:
- Producer side of the interpolation unit's pixel stream.
- Accepts one feature request: an integer pixel position plus a fractional part.
- Presents the fractional part to the interpolation unit as a one-cycle feature_x_dec/feature_y_dec/feature_val beat.
- Then fetches the (win_dim+1)x(win_dim+1) window around the feature from image memory and streams the pixels row-major on pix/pix_val, with credit-limited memory reads and output backpressure.

Parameters:
- pix_width, 9, pixel bits (matches the interpolation unit).
- dec_width, 15, fractional coordinate bits.
- int_width, 10, integer coordinate bits (unsigned).
- img_w, 16, image width in pixels; row stride for address generation.
- img_h, 16, image height in pixels; used only by the optional clamp.
- addr_width, 20, memory word address bits.
- buf_depth, 4, response buffer entries; also the maximum number of outstanding reads plus buffered pixels.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- win_dim, input, 5: window extent minus one; sampled at request accept.
- req_val, input, 1: feature request valid.
- req_rdy, output, 1: streamer idle and able to accept a request.
- req_x_int, input, int_width: feature column.
- req_y_int, input, int_width: feature row.
- req_x_dec, input, dec_width: fractional column.
- req_y_dec, input, dec_width: fractional row.
- feature_x_dec, output, dec_width: latched req_x_dec.
- feature_y_dec, output, dec_width: latched req_y_dec.
- feature_val, output, 1: one-cycle fraction beat.
- mem_req_val, output, 1: memory read request valid.
- mem_req_rdy, input, 1: memory accepts the request.
- mem_req_addr, output, addr_width: word address.
- mem_resp_val, input, 1: read data valid. Responses return in order with no rdy.
- mem_resp_data, input, pix_width: read data.
- pix, output, pix_width: window pixel.
- pix_val, output, 1: pix valid.
- pix_rdy, input, 1: consumer takes pix.
- row_counter, output, 5: row of the next pixel to issue.
- col_counter, output, 5: column of the next pixel to issue.
- done, output, 1: one-cycle pulse after the last pixel is consumed.

Behaviour:
- Reset values:
  - State IDLE; all counters and the buffer empty.
  - All outputs 0 except req_rdy=1.
- FSM states: IDLE, FEAT, STREAM, DRAIN.
- IDLE:
  - req_rdy=1.
  - On req_val&req_rdy, latch x_int, y_int, x_dec, y_dec and win_dim; go to FEAT.
  - mem_resp_val is ignored in IDLE.
- FEAT (exactly one cycle):
  - feature_val=1; feature_x_dec/feature_y_dec hold the latched values (they hold until the next accept).
  - Go to STREAM.
- Window origin:
  - half = win_dim>>1; ox = x_int-half; oy = y_int-half.
  - Both are computed mod 2^int_width.
- STREAM (issue):
  - mem_req_val=1 when credit < buf_depth, where credit = in_flight + buffer occupancy.
  - mem_req_addr = (oy+row_counter)*img_w + (ox+col_counter), truncated to addr_width.
  - On mem_req_val&mem_req_rdy, col_counter increments.
  - When col_counter==win_dim it wraps to 0 and row_counter increments.
  - Issuing pixel (win_dim, win_dim) moves the FSM to DRAIN.
- Response handling (STREAM/DRAIN):
  - mem_resp_val pushes into the buffer and decrements in_flight.
  - pix_val = buffer non-empty; pix = buffer head.
  - A pop occurs on pix_val&pix_rdy.
  - Issue and pop in the same cycle leave credit unchanged.
  - The credit rule guarantees the buffer never overflows.
  - Combinational path from mem_resp to pix is not allowed; the first pixel appears the cycle after its response.
- DRAIN:
  - Once all (win_dim+1)^2 pixels have been popped, done=1 for one cycle; return to IDLE with req_rdy=1 in that same cycle.
  - Back-to-back requests are therefore possible from the done cycle.
- Latency:
  - Accept at cycle t; feature_val at t+1; first mem_req_val at t+2.
  - First pix_val one cycle after the first mem_resp_val.
- win_dim=0: single pixel at (ox, oy) = (x_int, y_int); done after its pop.
- Counters reset to 0 at each accept. A win_dim change mid-request has no effect.
- Reset mid-operation: returns to IDLE immediately, discarding buffer, counters and credit. Memory is on the same reset, so no stale responses.

Optional Feature:
- Macro: WINDOW_PIXEL_STREAMER_CLAMP_EN.
- When defined:
  - Origin is computed signed.
  - Each fetched column is clamped to [0, img_w-1] and each row to [0, img_h-1] before address generation, replicating edge pixels.
  - Pixel count and order are unchanged.
- When undefined: no clamping; the caller guarantees the window lies inside the image, and wraparound follows the mod rule above.

Test Plan:
- Basic 3x3 fetch: img_w=16, memory[a]=a&0x1FF, win_dim=2, x_int=5, y_int=5, x_dec=0x2000, y_dec=0x1000, pix_rdy=1, one-cycle memory.
  - feature_val one cycle with 0x2000/0x1000.
  - Addresses 68,69,70,84,85,86,100,101,102.
  - pix streams the same values; done once; req_rdy=1.
- Backpressure: same as the basic case with pix_rdy low for 10 cycles after the first pix_val.
  - At most buf_depth reads are outstanding or buffered.
  - No pixel lost or duplicated; order preserved.
- mem_req_rdy stalls: random 50% mem_req_rdy.
  - Address sequence identical to the basic case; mem_req_addr stable while mem_req_val&!mem_req_rdy.
- win_dim=0 at x=3, y=2: single address 35 and single pixel; done two cycles after that response.
- Reset mid-stream: assert reset after 4 pixels are popped.
  - Next cycle: req_rdy=1, pix_val=0, counters 0.
  - A new request then completes correctly.
- Clamp (with macro): x=0, y=0, win_dim=2.
  - Addresses 0,0,1,0,0,1,16,16,17.
  - Without the macro, the bench only uses in-bounds windows.
